// File: rtl/link_frame_rx.sv
// Receive end of the single-wire framed link: oversamples the line,
// deframes start/data/even-parity/stop and hands words over valid/ready.
module link_frame_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire               VDD,
    inout  wire               VSS,
    input  logic              serial_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic line;
    logic samp;
    logic frame_end;
    logic par_bad;
    logic good;
    logic load;
    logic unused_pwr;

    // Supply pins exist for the physical netlist only.
    assign unused_pwr = VDD ^ VSS;
    assign line       = sync_q[1];

    always_comb begin
        samp = 1'b0;
        unique case (state_q)
            START:              samp = (cnt_q == HALF);
            DATA, PARITY, STOP: samp = (cnt_q == FULL);
            default:            samp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (line) state_d = START;
            end
            START: begin
                if (samp) state_d = line ? DATA : IDLE;
            end
            DATA: begin
                if (samp && bit_q == LAST) state_d = PARITY;
            end
            PARITY: begin
                if (samp) state_d = STOP;
            end
            STOP: begin
                if (samp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        sync_d  = {sync_q[0], serial_in};
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        // Phase counter: 1 on the cycle after t0 or after any sample.
        if (state_q == IDLE || samp) begin
            cnt_d = CW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (state_q == IDLE) bit_d = '0;
        if (state_q == DATA && samp) begin
            bit_d              = bit_q + BW'(1);
            shift_d            = shift_q >> 1;
            shift_d[DATA_W-1]  = line;
        end
        if (state_q == PARITY && samp) par_d = line;

        frame_end    = (state_q == STOP) && samp;
        par_bad      = ^{shift_q, par_q};
        good         = frame_end && !line && !par_bad;
        load         = good && (!rx_valid_q || rx_ready);
        rx_data_d    = load ? shift_q : rx_data_q;
        rx_valid_d   = load || (rx_valid_q && !rx_ready);
        frame_err_d  = frame_end && line;
        parity_err_d = frame_end && !line && par_bad;
        overrun_d    = (good && rx_valid_q && !rx_ready)
                     || (overrun_q && !ovr_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_link_frame_rx.sv
// Randomized bench for link_frame_rx against a frame-level
// reference model of line timing, frame outcomes and the handshake.
module tb_link_frame_rx;
    localparam int DW   = 8;
    localparam int CPB  = 4;
    localparam int MAXC = 20000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          serial_in;
    logic          rx_ready;
    logic          ovr_clr;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic          busy;
    wire           vdd;
    wire           vss;

    assign vdd = 1'b1;
    assign vss = 1'b0;

    link_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .VDD        (vdd),
        .VSS        (vss),
        .serial_in  (serial_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          glitch;
        logic [7:0]  w;
        bit          bp;
        bit          bs;
        int          gap;
        int          rdy;
    } item_t;

    item_t      items[$];
    logic       pq[$];
    int         ev_t [MAXC];
    logic [7:0] ev_w [MAXC];
    bit         busy_exp [MAXC];
    int         cyc;
    int         n_cmp;
    int         n_bad;
    int         rdy_pct;
    logic       exp_v;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_ovr;
    logic [7:0] exp_d;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     tag, cyc, got, want);
        end
    endtask

    function automatic item_t mk(bit g, logic [7:0] w, bit bp, bit bs,
                                 int gap, int rdy);
        item_t it;
        it.glitch = g;
        it.w      = w;
        it.bp     = bp;
        it.bs     = bs;
        it.gap    = gap;
        it.rdy    = rdy;
        return it;
    endfunction

    // Pin cycle c carries the first bit; line sees it at t0 = c+2.
    task automatic push_item(input item_t it);
        int   c;
        logic p;
        rdy_pct = it.rdy;
        c = cyc + it.gap;
        repeat (it.gap) pq.push_back(1'b0);
        if (it.glitch) begin
            pq.push_back(1'b1);
            repeat (3) pq.push_back(1'b0);
            busy_exp[c+3] = 1'b1;
            busy_exp[c+4] = 1'b1;
        end else begin
            p = (^it.w) ^ it.bp;
            repeat (CPB) pq.push_back(1'b1);
            for (int i = 0; i < DW; i++) begin
                repeat (CPB) pq.push_back(it.w[i]);
            end
            repeat (CPB) pq.push_back(p);
            repeat (CPB-1) pq.push_back(it.bs);
            pq.push_back(1'b0);
            for (int i = c + 3; i <= c + 44; i++) busy_exp[i] = 1'b1;
            ev_t[c+44] = it.bs ? 3 : (it.bp ? 2 : 1);
            ev_w[c+44] = it.w;
        end
    endtask

    task automatic advance();
        logic v_old;
        v_old  = exp_v;
        exp_pe = 1'b0;
        exp_fe = 1'b0;
        if (!rst_n) begin
            exp_v   = 1'b0;
            exp_d   = '0;
            exp_ovr = 1'b0;
            return;
        end
        if (ovr_clr) exp_ovr = 1'b0;
        if (v_old && rx_ready) exp_v = 1'b0;
        case (ev_t[cyc])
            1: begin
                if (!v_old || rx_ready) begin
                    exp_v = 1'b1;
                    exp_d = ev_w[cyc];
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            2:       exp_pe = 1'b1;
            3:       exp_fe = 1'b1;
            default: ;
        endcase
    endtask

    task automatic compare();
        check("rx_valid",   32'(rx_valid),   32'(exp_v));
        check("rx_data",    32'(rx_data),    32'(exp_d));
        check("parity_err", 32'(parity_err), 32'(exp_pe));
        check("frame_err",  32'(frame_err),  32'(exp_fe));
        check("overrun",    32'(overrun),    32'(exp_ovr));
        check("busy",       32'(busy),       32'(busy_exp[cyc] & rst_n));
    endtask

    task automatic step();
        if (pq.size() == 0 && items.size() > 0) push_item(items.pop_front());
        serial_in = (pq.size() > 0) ? pq.pop_front() : 1'b0;
        rx_ready  = ($urandom_range(99) < rdy_pct);
        ovr_clr   = ($urandom_range(15) == 0);
        advance();
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        item_t it;
        int    c;
        rst_n     = 1'b0;
        serial_in = 1'b0;
        rx_ready  = 1'b0;
        ovr_clr   = 1'b0;
        cyc       = 0;
        n_cmp     = 0;
        n_bad     = 0;
        rdy_pct   = 100;
        exp_v     = 1'b0;
        exp_d     = '0;
        exp_pe    = 1'b0;
        exp_fe    = 1'b0;
        exp_ovr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare();
        rst_n = 1'b1;

        items.push_back(mk(0, 8'hA5, 0, 0, 2, 100));
        items.push_back(mk(0, 8'h01, 1, 0, 3, 100));
        items.push_back(mk(0, 8'h3C, 1, 1, 0, 100));
        items.push_back(mk(0, 8'h11, 0, 0, 2, 0));
        items.push_back(mk(0, 8'h22, 0, 0, 0, 0));
        items.push_back(mk(1, 8'h00, 0, 0, 5, 0));
        items.push_back(mk(0, 8'h33, 0, 0, 0, 100));
        for (int i = 0; i < 120; i++) begin
            it.glitch = ($urandom_range(9) == 0);
            it.w      = 8'($urandom);
            it.bp     = ($urandom_range(7) == 0);
            it.bs     = ($urandom_range(7) == 0);
            it.gap    = $urandom_range(6);
            case ($urandom_range(2))
                0:       it.rdy = 0;
                1:       it.rdy = 30;
                default: it.rdy = 100;
            endcase
            items.push_back(it);
        end
        while (items.size() > 0 || pq.size() > 0) step();
        repeat (60) step();

        // Abandon a frame at its k=4 sample with a reset.
        c = cyc;
        items.push_back(mk(0, 8'h5A, 0, 0, 0, 100));
        while (cyc < c + 20) step();
        rst_n = 1'b0;
        pq.delete();
        for (int i = cyc + 1; i < MAXC; i++) begin
            ev_t[i]     = 0;
            busy_exp[i] = 1'b0;
        end
        repeat (4) step();
        rst_n = 1'b1;
        items.push_back(mk(0, 8'h5A, 0, 0, 2, 100));
        while (items.size() > 0 || pq.size() > 0) step();
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
